// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch/branch sequencer.
//   - 3-bit state encodings and the FSM state type
//   - control-flow opcode constants (instr[15:12])
//   - sticky error codes reported on err_o
package fetch_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        DECODE = ST_DECODE,
        EXEC   = ST_EXEC,
        UPDATE = ST_UPDATE,
        ERR    = ST_ERR
    } state_t;

    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_BZ  = 4'hD;
    localparam logic [3:0] OP_BNZ = 4'hE;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FETCH = 2'b01;
    localparam logic [1:0] ERR_EXEC  = 2'b10;

endpackage

// File: rtl/wait_timer.sv
// wait_timer: 8-bit wait-cycle counter shared by the FETCH and EXEC waits.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous reset, active-low (count -> 0)
//   clear_i    restart the count (asserted on every state change)
//   en_i       count this cycle (state is waiting)
//   limit_i    number of waiting cycles allowed
//   expired_o  this is the last allowed waiting cycle; the caller errors out
//              unless its ack/done arrives in this same cycle
module wait_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 8'd0;
        end else if (clear_i) begin
            count_q <= 8'd0;
        end else if (en_i && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Counting the current cycle, the limit is reached now.
    assign expired_o = en_i && (({1'b0, count_q} + 9'd1) >= {1'b0, limit_i});

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: multi-cycle fetch/branch sequencer driving the PC datapath.
// Ports:
//   clk_i, rst_ni           clock (rising edge), synchronous active-low reset
//   pc_i                    current PC; fetch address and jump page
//   imem_req_o/imem_ack_i   instruction-memory handshake, imem_rdata_i word
//   instr_o                 latched instruction word
//   exec_start_o            one-cycle start pulse for ordinary instructions
//   exec_done_i             datapath completion (sampled only in EXEC)
//   zero_flag_i             datapath zero flag (sampled in DECODE)
//   pc_update_o             one pulse per retired instruction
//   jump_o/branch_o         PC load / PC add controls, valid with pc_update_o
//   disp_o, jump_tgt_o      branch displacement and jump target
//   busy_o                  high outside IDLE and ERR
//   err_o                   sticky error: 01 fetch timeout, 10 exec timeout
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT  = 15,
    parameter int unsigned EXEC_TIMEOUT = 63
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] pc_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] instr_o,
    output logic        exec_start_o,
    input  logic        exec_done_i,
    input  logic        zero_flag_i,
    output logic        pc_update_o,
    output logic        jump_o,
    output logic        branch_o,
    output logic [7:0]  disp_o,
    output logic [15:0] jump_tgt_o,
    output logic        busy_o,
    output logic [1:0]  err_o
);

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [1:0]  err_q, err_d;
    logic        jump_q, jump_d;
    logic        branch_q, branch_d;
    logic        exec_start;
    logic        tmr_en;
    logic        tmr_expired;
    logic [7:0]  tmr_limit;

    assign tmr_en    = (state_q == FETCH) || (state_q == EXEC);
    assign tmr_limit = (state_q == EXEC) ? 8'(EXEC_TIMEOUT) : 8'(ACK_TIMEOUT);

    wait_timer u_wait_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_d != state_q),
        .en_i      (tmr_en),
        .limit_i   (tmr_limit),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            instr_q  <= 16'h0000;
            err_q    <= ERR_NONE;
            jump_q   <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            jump_q   <= jump_d;
            branch_q <= branch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        err_d      = err_q;
        jump_d     = jump_q;
        branch_d   = branch_q;
        exec_start = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // An ack in the final allowed cycle takes priority over the timeout.
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = DECODE;
                end else if (tmr_expired) begin
                    err_d   = ERR_FETCH;
                    state_d = ERR;
                end
            end
            DECODE: begin
                // Only one of jump/branch can be set, so they never overlap.
                jump_d   = 1'b0;
                branch_d = 1'b0;
                state_d  = UPDATE;
                case (instr_q[15:12])
                    OP_JMP:  jump_d   = 1'b1;
                    OP_BZ:   branch_d = zero_flag_i;
                    OP_BNZ:  branch_d = ~zero_flag_i;
                    default: begin
                        exec_start = 1'b1;
                        state_d    = EXEC;
                    end
                endcase
            end
            EXEC: begin
                if (exec_done_i) begin
                    state_d = UPDATE;
                end else if (tmr_expired) begin
                    err_d   = ERR_EXEC;
                    state_d = ERR;
                end
            end
            UPDATE:  state_d = FETCH;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_o   = (state_q == FETCH);
    assign instr_o      = instr_q;
    assign exec_start_o = exec_start;
    assign pc_update_o  = (state_q == UPDATE);
    assign jump_o       = (state_q == UPDATE) && jump_q;
    assign branch_o     = (state_q == UPDATE) && branch_q;
    assign disp_o       = instr_q[7:0];
    assign jump_tgt_o   = {pc_i[15:12], instr_q[11:0]};
    assign busy_o       = (state_q != IDLE) && (state_q != ERR);
    assign err_o        = err_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed-vector bench for fetch_seq.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [15:0] pc_i;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic [15:0] imem_rdata_i;
    logic [15:0] instr_o;
    logic        exec_start_o;
    logic        exec_done_i;
    logic        zero_flag_i;
    logic        pc_update_o;
    logic        jump_o;
    logic        branch_o;
    logic [7:0]  disp_o;
    logic [15:0] jump_tgt_o;
    logic        busy_o;
    logic [1:0]  err_o;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_seq #(.ACK_TIMEOUT(15), .EXEC_TIMEOUT(63)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .pc_i         (pc_i),
        .imem_req_o   (imem_req_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_o      (instr_o),
        .exec_start_o (exec_start_o),
        .exec_done_i  (exec_done_i),
        .zero_flag_i  (zero_flag_i),
        .pc_update_o  (pc_update_o),
        .jump_o       (jump_o),
        .branch_o     (branch_o),
        .disp_o       (disp_o),
        .jump_tgt_o   (jump_tgt_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the sequencer requests a fetch.
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!imem_req_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, 32'(imem_req_o), 32'd1);
    endtask

    task automatic ack_word(input logic [15:0] w);
        imem_ack_i   = 1'b1;
        imem_rdata_i = w;
        tick();
        imem_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_ni = 1'b0; pc_i = 16'h0000; imem_ack_i = 1'b0; imem_rdata_i = 16'h0000;
        exec_done_i = 1'b0; zero_flag_i = 1'b0;

        // Reset state
        do_reset();
        check("rst_instr", 32'(instr_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("idle_busy", 32'(busy_o), 32'h0);
        check("idle_req", 32'(imem_req_o), 32'h0);
        tick();
        check("fetch_req", 32'(imem_req_o), 32'h1);

        // Ordinary instruction, ack 2 cycles after req, done 3 cycles after start
        tick();
        tick();
        ack_word(16'h1234);
        check("alu_instr", 32'(instr_o), 32'h1234);
        check("alu_start", 32'(exec_start_o), 32'h1);
        check("alu_req_drop", 32'(imem_req_o), 32'h0);
        tick();
        check("alu_start_once", 32'(exec_start_o), 32'h0);
        check("alu_no_upd", 32'(pc_update_o), 32'h0);
        tick();
        tick();
        exec_done_i = 1'b1;
        tick();
        exec_done_i = 1'b0;
        check("alu_upd", 32'(pc_update_o), 32'h1);
        check("alu_jump", 32'(jump_o), 32'h0);
        check("alu_branch", 32'(branch_o), 32'h0);
        tick();
        check("alu_upd_once", 32'(pc_update_o), 32'h0);

        // JMP
        pc_i = 16'hA010;
        wait_req("jmp");
        ack_word(16'hC345);
        check("jmp_no_start", 32'(exec_start_o), 32'h0);
        tick();
        check("jmp_upd", 32'(pc_update_o), 32'h1);
        check("jmp_jump", 32'(jump_o), 32'h1);
        check("jmp_branch", 32'(branch_o), 32'h0);
        check("jmp_tgt", 32'(jump_tgt_o), 32'hA345);
        tick();
        check("jmp_back_to_fetch", 32'(imem_req_o), 32'h1);

        // BZ taken / not taken, BNZ taken
        wait_req("bz1");
        ack_word(16'hD0FC);
        zero_flag_i = 1'b1;
        tick();
        zero_flag_i = 1'b0;
        check("bz1_upd", 32'(pc_update_o), 32'h1);
        check("bz1_branch", 32'(branch_o), 32'h1);
        check("bz1_jump", 32'(jump_o), 32'h0);
        check("bz1_disp", 32'(disp_o), 32'hFC);
        wait_req("bz0");
        ack_word(16'hD0FC);
        zero_flag_i = 1'b0;
        tick();
        check("bz0_upd", 32'(pc_update_o), 32'h1);
        check("bz0_branch", 32'(branch_o), 32'h0);
        wait_req("bnz");
        ack_word(16'hE005);
        zero_flag_i = 1'b0;
        tick();
        check("bnz_branch", 32'(branch_o), 32'h1);
        check("bnz_disp", 32'(disp_o), 32'h05);
        tick();
        check("bnz_branch_clr", 32'(branch_o), 32'h0);

        // Reset mid-FETCH with an ack in the reset cycle
        wait_req("rstf");
        rst_ni = 1'b0;
        ack_word(16'hBEEF);
        rst_ni = 1'b1;
        check("rstf_instr", 32'(instr_o), 32'h0);
        check("rstf_idle_busy", 32'(busy_o), 32'h0);
        check("rstf_idle_req", 32'(imem_req_o), 32'h0);

        // Reset mid-EXEC
        wait_req("rste");
        ack_word(16'h2222);
        tick();
        check("rste_in_exec", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        exec_done_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        exec_done_i = 1'b0;
        check("rste_no_upd", 32'(pc_update_o), 32'h0);
        check("rste_idle_req", 32'(imem_req_o), 32'h0);
        tick();
        check("rste_no_upd2", 32'(pc_update_o), 32'h0);
        check("rste_req_rise", 32'(imem_req_o), 32'h1);

        // Ack in the last allowed FETCH cycle wins over the timeout
        for (int i = 0; i < 14; i++) tick();
        ack_word(16'h3333);
        check("lastack_err", 32'(err_o), 32'h0);
        check("lastack_instr", 32'(instr_o), 32'h3333);
        // done in the exec_start cycle is ignored, then exec timeout
        exec_done_i = 1'b1;
        tick();
        exec_done_i = 1'b0;
        tick();
        check("early_done_ignored", 32'(pc_update_o), 32'h0);
        for (int i = 0; i < 61; i++) tick();
        check("exec_pre_to_busy", 32'(busy_o), 32'h1);
        check("exec_pre_to_err", 32'(err_o), 32'h0);
        tick();
        check("exec_to_err", 32'(err_o), 32'h2);
        check("exec_to_busy", 32'(busy_o), 32'h0);

        // Fetch timeout: never ack
        do_reset();
        wait_req("fto");
        for (int i = 0; i < 14; i++) tick();
        check("fto_pre_err", 32'(err_o), 32'h0);
        check("fto_pre_req", 32'(imem_req_o), 32'h1);
        tick();
        check("fto_err", 32'(err_o), 32'h1);
        check("fto_busy", 32'(busy_o), 32'h0);
        check("fto_req", 32'(imem_req_o), 32'h0);
        ack_word(16'h4444);
        tick();
        check("fto_sticky_err", 32'(err_o), 32'h1);
        check("fto_stay_err", 32'(busy_o), 32'h0);
        check("fto_instr_kept", 32'(instr_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Multi-cycle fetch/branch sequencer that drives the program-counter datapath.
- Sequence per instruction:
  - Requests an instruction word from instruction memory via a req/ack handshake.
  - Decodes control-flow opcodes (JMP, BZ, BNZ).
  - Hands ordinary instructions to the execute datapath and waits for completion.
  - Issues exactly one PC-update pulse, with jump/branch controls, per retired instruction.
- Sits between the PC register, instruction memory and the ALU datapath.

Parameters:
- ACK_TIMEOUT, 15: max cycles waiting for imem_ack_i before a fetch error (1..255).
- EXEC_TIMEOUT, 63: max cycles waiting for exec_done_i before an exec error (1..255).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous reset, active-low.
- pc_i  in  16  current PC (instruction pointer from the PC block).
- imem_req_o  out  1  fetch request to instruction memory; address is pc_i.
- imem_ack_i  in  1  memory returns imem_rdata_i valid this cycle.
- imem_rdata_i  in  16  fetched instruction word.
- instr_o  out  16  latched instruction presented to the datapath.
- exec_start_o  out  1  one-cycle pulse: datapath begins instr_o.
- exec_done_i  in  1  datapath finished; flags valid.
- zero_flag_i  in  1  zero flag from the datapath (sampled in DECODE).
- pc_update_o  out  1  one-cycle PC clock-enable/advance pulse.
- jump_o  out  1  with pc_update_o: load jump_tgt_o.
- branch_o  out  1  with pc_update_o: add sign-extended disp_o.
- disp_o  out  8  branch displacement (instr[7:0]).
- jump_tgt_o  out  16  {pc_i[15:12], instr[11:0]}.
- busy_o  out  1  high in every state except IDLE and ERR.
- err_o  out  2  sticky: 01 fetch timeout, 10 exec timeout, 00 none.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - State enters IDLE.
  - All outputs 0: instr_o=16'h0000, err_o=2'b00, timeout counter 0.
  - Reset mid-handshake abandons the fetch; a late imem_ack_i is ignored.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, ERR.
- IDLE:
  - Remains IDLE for exactly one cycle after reset deasserts, then goes to FETCH.
- FETCH:
  - imem_req_o=1, held until ack.
  - On imem_ack_i=1: latch imem_rdata_i into instr_o; go to DECODE.
  - imem_req_o drops in the cycle after the ack.
  - The counter increments each cycle without ack. If it reaches ACK_TIMEOUT: err_o=01, go to ERR.
- DECODE (1 cycle), by opcode = instr_o[15:12]:
  - 4'hC (JMP): go to UPDATE with jump=1.
  - 4'hD (BZ): branch=zero_flag_i.
  - 4'hE (BNZ): branch=~zero_flag_i.
  - Any other opcode: exec_start_o=1 for this cycle only, then go to EXEC.
  - BZ/BNZ go to UPDATE; a not-taken branch behaves as a normal +1.
- EXEC:
  - Wait for exec_done_i=1, then go to UPDATE.
  - Timeout counter (restarted on entry) as in FETCH; at EXEC_TIMEOUT: err_o=10, go to ERR.
  - exec_done_i in the same cycle as exec_start_o is ignored; done is sampled only in EXEC.
- UPDATE (1 cycle):
  - pc_update_o=1.
  - jump_o / branch_o are the registered decode results.
  - disp_o and jump_tgt_o are stable during the pulse.
  - Next state FETCH.
  - jump_o and branch_o are never both 1; jump has priority by construction.
- ERR:
  - All strobes 0, busy_o=0; held until reset.
  - err_o stays sticky.
- Outputs:
  - jump_o, branch_o and pc_update_o are 0 outside UPDATE.
  - disp_o and jump_tgt_o are combinational from instr_o and pc_i.
- Timeout counter:
  - 8-bit, restarted on every state entry.
  - An ack/done arriving in the same cycle the count reaches the limit wins (no error).
- Throughput: a back-to-back JMP/branch takes 3 cycles plus the ack latency.

Decomposition:
- Shared package fetch_pkg:
  - state encoding localparams (3-bit);
  - opcode constants OP_JMP=4'hC, OP_BZ=4'hD, OP_BNZ=4'hE;
  - error codes ERR_NONE/ERR_FETCH/ERR_EXEC.
- Sub-module wait_timer:
  - Loadable 8-bit up-counter: clear on state change, expired output at the parameterized limit.
  - Instantiated once, with the limit muxed by state.

Test Plan:
- Reset, then imem_ack_i 2 cycles after req with rdata=16'h1234:
  - instr_o=16'h1234, exec_start_o one pulse.
  - exec_done_i after 3 cycles → pc_update_o one pulse, jump_o=0, branch_o=0.
- pc_i=16'hA010, fetch 16'hC345 → UPDATE with jump_o=1, jump_tgt_o=16'hA345, no exec_start_o.
- Fetch 16'hD0FC with zero_flag_i=1 → branch_o=1, disp_o=8'hFC.
- Same word with zero_flag_i=0 → branch_o=0, pc_update_o=1.
- Fetch 16'hE005 with zero_flag_i=0 → branch_o=1, disp_o=8'h05.
- Never ack:
  - after ACK_TIMEOUT=15 waiting cycles → err_o=01, busy_o=0;
  - a subsequent imem_ack_i leaves state in ERR.
- Deassert rst_ni mid-FETCH, then ack in the reset cycle → instr_o=0, IDLE.
- Deassert rst_ni mid-EXEC:
  - no pc_update_o is emitted;
  - IDLE is held one cycle, then imem_req_o rises.
